// File: rtl/registrador_solicitudes.sv
// Request register: sync, debounce, edge-detect and latch of 10 buttons.
// Optional cabin-call cancellation toggle under REGISTRADOR_CANCELACION_EN.
module registrador_solicitudes #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] botones,
  input  logic       atender,
  input  logic [1:0] piso_actual,
  input  logic       direccion,
  output logic [9:0] pendientes,
  output logic [9:0] luces,
  output logic       hay_solicitud,
  output logic       nueva_solicitud
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [9:0] CABINA = 10'h3C0;

  logic [9:0]       s1;
  logic [9:0]       s2;
  logic [9:0]       deb;
  logic [9:0]       deb_q;
  logic [CNT_W-1:0] cnt [10];
  logic [9:0]       pend_r;
  logic             nueva_r;
  logic [9:0]       press;
  logic [9:0]       clear_mask;
  logic [9:0]       pend_next;

  // Two-flop synchroniser on every raw button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= botones;
      s2 <= s1;
    end
  end

  // Per-bit debounce: accept a new level after enough stable cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 10; i++) cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 10; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  // Requests served at the current floor in the committed direction.
  always_comb begin
    clear_mask = '0;
    if (atender) begin
      unique case (piso_actual)
        2'd0: begin
          clear_mask[6] = 1'b1;
          clear_mask[0] = 1'b1;
        end
        2'd1: begin
          clear_mask[7] = 1'b1;
          if (direccion) clear_mask[2] = 1'b1;
          else           clear_mask[1] = 1'b1;
        end
        2'd2: begin
          clear_mask[8] = 1'b1;
          if (direccion) clear_mask[4] = 1'b1;
          else           clear_mask[3] = 1'b1;
        end
        2'd3: begin
          clear_mask[9] = 1'b1;
          clear_mask[5] = 1'b1;
        end
        default: clear_mask = '0;
      endcase
    end
  end

  // Latch presses, optionally toggle cabin calls off, then apply clears.
  always_comb begin
    pend_next = pend_r | press;
`ifdef REGISTRADOR_CANCELACION_EN
    pend_next = pend_next & ~(press & pend_r & CABINA);
`else
    pend_next = pend_next & (pend_r | ~pend_r | CABINA);
`endif
    pend_next = pend_next & ~clear_mask;
  end

  // Pending register and new-request pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r  <= '0;
      nueva_r <= 1'b0;
    end else begin
      pend_r  <= pend_next;
      nueva_r <= |(pend_next & ~pend_r);
    end
  end

  assign pendientes      = pend_r;
  assign luces           = pend_r;
  assign hay_solicitud   = |pend_r;
  assign nueva_solicitud = nueva_r;

endmodule

// File: tb/tb_registrador_solicitudes.sv
// Bench for registrador_solicitudes: directed cases plus random stimulus
// checked against a sample-window reference model.
module tb_registrador_solicitudes;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] botones;
  logic       atender;
  logic [1:0] piso_actual;
  logic       direccion;
  logic [9:0] pendientes;
  logic [9:0] luces;
  logic       hay_solicitud;
  logic       nueva_solicitud;

  int n_cmp = 0;
  int n_bad = 0;

  registrador_solicitudes #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .botones(botones),
    .atender(atender),
    .piso_actual(piso_actual),
    .direccion(direccion),
    .pendientes(pendientes),
    .luces(luces),
    .hay_solicitud(hay_solicitud),
    .nueva_solicitud(nueva_solicitud)
  );

  always #5 clk = ~clk;

  // Model state
  logic [9:0] hist [$];
  logic [9:0] m_deb;
  logic [9:0] m_deb_q;
  logic [9:0] m_pend;
  logic       m_nueva;

  task automatic check(string tag, logic [9:0] got, logic [9:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back('0);
    m_deb   = '0;
    m_deb_q = '0;
    m_pend  = '0;
    m_nueva = 1'b0;
  endtask

  function automatic logic [9:0] served(int p, logic dir);
    logic [9:0] m;
    int h;
    m = '0;
    m[6 + p] = 1'b1;
    if (p == 0) h = 0;
    else if (p == 3) h = 5;
    else h = dir ? 2 * p : 2 * p - 1;
    m[h] = 1'b1;
    return m;
  endfunction

  // One rising edge as seen by the reference model.
  task automatic model_edge();
    logic [9:0] pr;
    logic [9:0] nx;
    logic [9:0] nd;
    int n;
    bit flip;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pr = m_deb & ~m_deb_q;
    nx = m_pend | pr;
`ifdef REGISTRADOR_CANCELACION_EN
    for (int i = 6; i < 10; i++)
      if (pr[i] && m_pend[i]) nx[i] = 1'b0;
`endif
    if (atender) nx = nx & ~served(int'(piso_actual), direccion);
    m_nueva = |(nx & ~m_pend);
    m_pend  = nx;
    n  = hist.size();
    nd = m_deb;
    for (int i = 0; i < 10; i++) begin
      flip = 1'b1;
      for (int j = n - 1 - D; j <= n - 2; j++)
        if (hist[j][i] == m_deb[i]) flip = 1'b0;
      if (flip) nd[i] = ~m_deb[i];
    end
    m_deb_q = m_deb;
    m_deb   = nd;
    hist.push_back(botones);
    if (hist.size() > D + 2) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pend", pendientes, m_pend);
    check("luces", luces, m_pend);
    check("hay", {9'd0, hay_solicitud}, {9'd0, |m_pend});
    check("nueva", {9'd0, nueva_solicitud}, {9'd0, m_nueva});
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    botones = '0;
    atender = 1'b0;
    steps(2);
    rst_n = 1'b1;
  endtask

  int seen_nueva;
  logic [9:0] lvl;

  initial begin
    rst_n = 1'b0;
    botones = '0;
    atender = 1'b0;
    piso_actual = '0;
    direccion = 1'b0;
    model_reset();
    steps(3);
    check("rst_pend", pendientes, 10'h000);
    check("rst_nueva", {9'd0, nueva_solicitud}, 10'h000);
    rst_n = 1'b1;
    steps(2);

    // Short glitch is rejected
    seen_nueva = 0;
    botones = 10'h080;
    steps(3);
    botones = '0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (nueva_solicitud) seen_nueva++;
    end
    check("glitch_pend", pendientes, 10'h000);
    check("glitch_nueva", 10'(seen_nueva), 10'h000);

    // Held press: latency D+3
    botones = 10'h080;
    steps(D + 2);
    check("lat_early", pendientes, 10'h000);
    step();
    check("lat_pend", pendientes, 10'h080);
    check("lat_nueva", {9'd0, nueva_solicitud}, 10'h001);
    check("lat_hay", {9'd0, hay_solicitud}, 10'h001);
    step();
    check("lat_nueva_off", {9'd0, nueva_solicitud}, 10'h000);
    botones = '0;
    steps(8);

    // Fill everything, then clear by floor/direction
    botones = 10'h3FF;
    steps(D + 3);
    check("all_pend", pendientes, 10'h3FF);
    botones = '0;
    steps(8);
    atender = 1'b1;
    piso_actual = 2'd1;
    direccion = 1'b1;
    step();
    check("clr_p1_up", pendientes, 10'h37B);
    piso_actual = 2'd3;
    step();
    check("clr_p3", pendientes, 10'h15B);
    step();
    check("clr_idem", pendientes, 10'h15B);
    atender = 1'b0;

    // Clear wins over simultaneous press on same bit
    do_reset();
    botones = 10'h011;
    steps(D + 2);
    atender = 1'b1;
    piso_actual = 2'd0;
    direccion = 1'b0;
    step();
    atender = 1'b0;
    check("clr_prio", pendientes, 10'h010);
    botones = '0;
    steps(8);

    // Held button does not re-request after clear
    do_reset();
    botones = 10'h100;
    steps(D + 3);
    check("hold_set", pendientes, 10'h100);
    atender = 1'b1;
    piso_actual = 2'd2;
    direccion = 1'b1;
    step();
    atender = 1'b0;
    check("hold_clr", pendientes, 10'h000);
    steps(10);
    check("hold_stay", pendientes, 10'h000);
    botones = '0;
    steps(8);
    botones = 10'h100;
    steps(D + 3);
    check("hold_repress", pendientes, 10'h100);
    botones = '0;
    steps(8);

    // Reset in the middle of a debounce
    do_reset();
    botones = 10'h008;
    steps(4);
    rst_n = 1'b0;
    botones = '0;
    step();
    check("rstmid_pend", pendientes, 10'h000);
    check("rstmid_nueva", {9'd0, nueva_solicitud}, 10'h000);
    rst_n = 1'b1;
    steps(12);
    check("rstmid_after", pendientes, 10'h000);

    // Second press on a lit cabin button
    do_reset();
    botones = 10'h200;
    steps(D + 3);
    check("cab_first", pendientes, 10'h200);
    botones = '0;
    steps(8);
    botones = 10'h200;
    steps(D + 3);
`ifdef REGISTRADOR_CANCELACION_EN
    check("cab_second", pendientes, 10'h000);
`else
    check("cab_second", pendientes, 10'h200);
`endif
    botones = '0;
    steps(8);

    // Random traffic
    lvl = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 10; i++)
        if ($urandom_range(0, 29) == 0) lvl[i] = ~lvl[i];
      botones = lvl;
      atender = ($urandom_range(0, 5) == 0);
      piso_actual = 2'($urandom_range(0, 3));
      direccion = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 799) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/registrador_solicitudes.md
Name: registrador_solicitudes

Overview:
- Request register stage that sits directly upstream of the elevator's dispatch algorithm.
- Takes the 10 raw call/cabin buttons, synchronises and debounces them, and latches each press as a pending request.
- Drives the button lights and the pending vector consumed by the algorithm.
- Clears requests when the algorithm reports that a floor is being served.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before a button level is accepted; legal range is 1 or more.
- CNT_W, 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- botones  input  10  raw asynchronous buttons, 1 = pressed. Bit mapping:
  - 0: floor 1 up
  - 1: floor 2 down
  - 2: floor 2 up
  - 3: floor 3 down
  - 4: floor 3 up
  - 5: floor 4 down
  - 6..9: cabin floors 1..4
- atender  input  1  one-cycle strobe from the algorithm: doors opening at piso_actual.
- piso_actual  input  2  current floor, 0..3 = floors 1..4.
- direccion  input  1  committed travel direction, 1 = up, 0 = down.
- pendientes  output  10  latched pending requests, same bit mapping as botones.
- luces  output  10  button lamps; equal to pendientes.
- hay_solicitud  output  1  OR-reduction of pendientes.
- nueva_solicitud  output  1  one-cycle pulse when any pendientes bit goes 0->1.

Behaviour:
- Reset, sampled while rst_n=0 at a clock edge:
  - pendientes, luces, hay_solicitud and nueva_solicitud are all 0.
  - Synchroniser flops, debounced levels, previous levels and counters are all 0.
  - Reset in the middle of a debounce or with pending requests discards everything; there is no carry-over.
- Synchroniser: two flops per bit (s1, s2).
- Debounce, per bit:
  - If s2 == deb, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and s2 != deb still holds, deb takes s2 at that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are never accepted.
- Edge detect: press = deb & ~deb_q, where deb_q is deb delayed by one cycle. Only rising edges set requests.
  - A button held down re-requests nothing after its request is cleared, until it is released and pressed again.
- Latency: pendientes[i] rises DEBOUNCE_CYCLES+3 rising edges after, and counting, the first edge that samples botones[i] high.
- Clear mask, computed when atender=1, with p = piso_actual:
  - Cabin bit 6+p.
  - Hall: if direccion=1 and p<3, bit 2p. If direccion=0 and p>0, bit 2p-1.
  - Terminal floors: p=0 always clears bit 0; p=3 always clears bit 5, regardless of direccion.
- Update: pendientes_next = (pendientes | press) & ~clear_mask.
  - Clear has priority over a simultaneous press on the same bit.
  - Presses on other bits in the same cycle are still latched.
- nueva_solicitud is registered: it is 1 in the cycle after an edge where any bit of (pendientes_next & ~pendientes) is 1.
- hay_solicitud is combinational from the pendientes register.
- atender with piso_actual unchanged on consecutive cycles is legal and idempotent.
- Multiple simultaneous presses are all latched in the same edge.

Optional Feature:
- Macro: REGISTRADOR_CANCELACION_EN.
- When defined: a press on a cabin bit (6..9) whose pendientes bit is already 1 clears it (toggle), with no nueva_solicitud.
  - Hall bits are unaffected.
  - Clear mask still has priority.
- When undefined: pressing an already-lit button has no effect.

Test Plan:
- DEBOUNCE_CYCLES=4, pulse botones[7] high for 3 cycles then low -> pendientes stays 10'h000, nueva_solicitud never asserted.
- DEBOUNCE_CYCLES=4, hold botones[7] high -> pendientes=10'h080 exactly 7 edges after first sampled-high edge; nueva_solicitud high for exactly 1 cycle; hay_solicitud=1.
- Pending 10'h3FF, atender with piso_actual=1, direccion=1 -> pendientes=10'h37B (clears bits 2 and 7); then piso_actual=3, direccion=1 -> 10'h15B (clears bits 5 and 9).
- Same cycle: debounced press on bit 0 and atender with piso_actual=0, direccion=0 -> bit 0 stays 0; a simultaneous press on bit 4 is latched -> pendientes=10'h010.
- Button 8 held continuously, cleared by atender at piso_actual=2 -> stays 0 while held; release, re-press -> set again. rst_n=0 during debounce -> all outputs 0 the next cycle, and no request appears after release of reset unless re-pressed.
- With REGISTRADOR_CANCELACION_EN: press bit 9 twice (separate presses) -> pendientes 10'h200 then 10'h000. Without the macro -> remains 10'h200.
